// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 captures operands and opcode, stage 2 executes
// and registers the result and flags. Elastic valid/ready handshake on both sides.
module alu_pipe #(
    parameter int NBITS  = 8,
    parameter int COD_OP = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [NBITS-1:0]  operando_A,
    input  logic [NBITS-1:0]  operando_B,
    input  logic [COD_OP-1:0] cod_operacion,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NBITS-1:0]  ALU_Result,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_ovf,
    output logic              o_err
);

    localparam int MSB = NBITS - 1;
    localparam logic [NBITS-1:0] SH_LIM = NBITS'(NBITS);

    localparam logic [COD_OP-1:0] OP_ADD = COD_OP'(6'b100000);
    localparam logic [COD_OP-1:0] OP_SUB = COD_OP'(6'b100010);
    localparam logic [COD_OP-1:0] OP_AND = COD_OP'(6'b100100);
    localparam logic [COD_OP-1:0] OP_OR  = COD_OP'(6'b100101);
    localparam logic [COD_OP-1:0] OP_XOR = COD_OP'(6'b100110);
    localparam logic [COD_OP-1:0] OP_NOR = COD_OP'(6'b100111);
    localparam logic [COD_OP-1:0] OP_SRA = COD_OP'(6'b000011);
    localparam logic [COD_OP-1:0] OP_SRL = COD_OP'(6'b000010);

    logic              s1_valid;
    logic [NBITS-1:0]  s1_a;
    logic [NBITS-1:0]  s1_b;
    logic [COD_OP-1:0] s1_op;
    logic              s2_valid;
    logic              adv1;
    logic              adv2;

    logic [NBITS:0]    sum;
    logic [NBITS:0]    diff;
    logic              shift_big;
    logic [NBITS-1:0]  res;
    logic              carry;
    logic              ovf;
    logic              err;

    assign adv2    = !s2_valid || i_ready;
    assign adv1    = adv2 || !s1_valid;
    assign o_ready = !s1_valid || !s2_valid || i_ready;
    assign o_valid = s2_valid;

    always_comb begin
        sum       = {1'b0, s1_a} + {1'b0, s1_b};
        diff      = {1'b0, s1_a} - {1'b0, s1_b};
        shift_big = (s1_b >= SH_LIM);
        res       = '0;
        carry     = 1'b0;
        ovf       = 1'b0;
        err       = 1'b0;
        unique case (s1_op)
            OP_ADD: begin
                res   = sum[MSB:0];
                carry = sum[NBITS];
                ovf   = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                // bit NBITS of the widened difference is the unsigned borrow
                res   = diff[MSB:0];
                carry = diff[NBITS];
                ovf   = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
            end
            OP_AND: res = s1_a & s1_b;
            OP_OR:  res = s1_a | s1_b;
            OP_XOR: res = s1_a ^ s1_b;
            OP_NOR: res = ~(s1_a | s1_b);
            OP_SRA: res = shift_big ? {NBITS{s1_a[MSB]}} : NBITS'($signed(s1_a) >>> s1_b);
            OP_SRL: res = shift_big ? '0 : (s1_a >> s1_b);
            default: err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (adv1) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_a  <= operando_A;
                s1_b  <= operando_B;
                s1_op <= cod_operacion;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            ALU_Result <= '0;
            o_zero     <= 1'b0;
            o_carry    <= 1'b0;
            o_ovf      <= 1'b0;
            o_err      <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                ALU_Result <= res;
                o_zero     <= (res == '0);
                o_carry    <= carry;
                o_ovf      <= ovf;
                o_err      <= err;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: stimulus pushes expected results, a negedge monitor
// pops and compares on every consumed output, and checks handshake and latency.
module tb_alu_pipe;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         e;
    } exp_t;

    typedef struct {
        exp_t e;
        int   acc_cyc;
        int   acc_stall;
    } entry_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] operando_A;
    logic [N-1:0] operando_B;
    logic [5:0]   cod_operacion;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] ALU_Result;
    logic         o_zero;
    logic         o_carry;
    logic         o_ovf;
    logic         o_err;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     stall_cnt = 0;
    exp_t   exp_pend;
    entry_t q[$];

    localparam logic [5:0] OPS [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                       6'b100110, 6'b100111, 6'b000011, 6'b000010};

    alu_pipe #(.NBITS(N), .COD_OP(6)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .operando_A(operando_A), .operando_B(operando_B), .cod_operacion(cod_operacion),
        .o_valid(o_valid), .i_ready(i_ready), .ALU_Result(ALU_Result),
        .o_zero(o_zero), .o_carry(o_carry), .o_ovf(o_ovf), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [N-1:0] r, logic z, logic c, logic v, logic e);
        exp_t x;
        x.res = r; x.z = z; x.c = c; x.v = v; x.e = e;
        return x;
    endfunction

    // Reference behaviour from integer arithmetic on the operand values
    function automatic exp_t model(logic [N-1:0] a, logic [N-1:0] b, logic [5:0] op);
        exp_t x;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int s;
        x = '0;
        case (op)
            6'b100000: begin
                x.res = N'(ua + ub); x.c = (ua + ub) > 255;
                s = sa + sb; x.v = (s > 127) || (s < -128);
            end
            6'b100010: begin
                x.res = N'(ua - ub); x.c = ua < ub;
                s = sa - sb; x.v = (s > 127) || (s < -128);
            end
            6'b100100: x.res = a & b;
            6'b100101: x.res = a | b;
            6'b100110: x.res = a ^ b;
            6'b100111: x.res = ~(a | b);
            6'b000011: x.res = (ub >= N) ? ((sa < 0) ? 8'hFF : 8'h00) : N'(sa >>> ub);
            6'b000010: x.res = (ub >= N) ? 8'h00 : N'(ua >> ub);
            default:   x.e = 1'b1;
        endcase
        x.z = (x.res == 0);
        return x;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            checks++;
            if (o_ready !== ((q.size() < 2) || i_ready)) begin
                failures++;
                $display("FAIL o_ready: got %b want %b (inflight=%0d i_ready=%b) cyc=%0d",
                         o_ready, (q.size() < 2) || i_ready, q.size(), i_ready, cyc);
            end
            if (o_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_valid: o_valid=1 with nothing in flight cyc=%0d", cyc);
                end else if ({ALU_Result, o_zero, o_carry, o_ovf, o_err} !== q[0].e) begin
                    failures++;
                    $display("FAIL result: got res=%h z%b c%b v%b e%b want res=%h z%b c%b v%b e%b cyc=%0d",
                             ALU_Result, o_zero, o_carry, o_ovf, o_err,
                             q[0].e.res, q[0].e.z, q[0].e.c, q[0].e.v, q[0].e.e, cyc);
                end
                if (q.size() != 0 && i_ready) begin
                    entry_t ent;
                    ent = q.pop_front();
                    if (ent.acc_stall == stall_cnt) begin
                        checks++;
                        if (cyc - ent.acc_cyc != 2) begin
                            failures++;
                            $display("FAIL latency: got %0d want 2 cyc=%0d", cyc - ent.acc_cyc, cyc);
                        end
                    end
                end
            end else begin
                checks++;
                if (q.size() >= 2) begin
                    failures++;
                    $display("FAIL missing_valid: o_valid=0 with %0d in flight cyc=%0d", q.size(), cyc);
                end
            end
            if (i_valid && o_ready) q.push_back('{exp_pend, cyc, stall_cnt});
            if (!i_ready) stall_cnt++;
        end
        cyc++;
    end

    task automatic chk_reset(input string tag);
        checks++;
        if ({o_valid, ALU_Result, o_zero, o_carry, o_ovf, o_err, o_ready} !== {1'b0, 8'h00, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL %s: got valid=%b res=%h z%b c%b v%b e%b rdy=%b want 0/00/0000/rdy1",
                     tag, o_valid, ALU_Result, o_zero, o_carry, o_ovf, o_err, o_ready);
        end
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [5:0] op, input exp_t e);
        bit acc = 0;
        i_valid = 1'b1; operando_A = a; operando_B = b; cod_operacion = op; exp_pend = e;
        for (int k = 0; k < 30 && !acc; k++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        operando_A = N'($urandom); operando_B = N'($urandom); cod_operacion = 6'($urandom);
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send_timeout: op %b not accepted within 30 cycles", op);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        operando_A = '0; operando_B = '0; cod_operacion = '0; exp_pend = '0;
        #2 chk_reset("reset_state");
        idle(3);
        rst_n = 1'b1;
        idle(1);

        send(8'h04, 8'h0C, 6'b100000, mk(8'h10, 0, 0, 0, 0));
        idle(4);

        send(8'h04, 8'h0C, 6'b100010, mk(8'hF8, 0, 1, 0, 0));
        send(8'h7F, 8'h01, 6'b100000, mk(8'h80, 0, 0, 1, 0));
        send(8'h04, 8'h0C, 6'b100111, mk(8'hF3, 0, 0, 0, 0));
        idle(4);

        send(8'h8C, 8'd2, 6'b000011, mk(8'hE3, 0, 0, 0, 0));
        send(8'h0C, 8'd3, 6'b000010, mk(8'h01, 0, 0, 0, 0));
        send(8'h80, 8'd9, 6'b000011, mk(8'hFF, 0, 0, 0, 0));
        send(8'hFF, 8'd8, 6'b000010, mk(8'h00, 1, 0, 0, 0));
        send(8'h55, 8'hAA, 6'b111111, mk(8'h00, 1, 0, 0, 1));
        send(8'h5A, 8'd0, 6'b000011, mk(8'h5A, 0, 0, 0, 0));
        idle(4);

        i_ready = 1'b0;
        fork
            begin
                send(8'h10, 8'h20, 6'b100000, mk(8'h30, 0, 0, 0, 0));
                send(8'h10, 8'h20, 6'b100010, mk(8'hF0, 0, 1, 0, 0));
                send(8'hF0, 8'h0F, 6'b100110, mk(8'hFF, 0, 0, 0, 0));
            end
            begin
                idle(6);
                i_ready = 1'b1;
            end
        join
        idle(4);

        send(8'h01, 8'h02, 6'b100000, mk(8'h03, 0, 0, 0, 0));
        send(8'h80, 8'h01, 6'b100010, mk(8'h7F, 0, 0, 1, 0));
        rst_n = 1'b0;
        #1 chk_reset("reset_midflight");
        idle(2);
        rst_n = 1'b1;
        idle(5);
        send(8'h7F, 8'h01, 6'b100000, mk(8'h80, 0, 0, 1, 0));
        idle(4);

        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] a, b;
            logic [5:0]   op;
            int           k;
            k  = $urandom_range(0, 9);
            op = (k < 8) ? OPS[k] : 6'($urandom);
            a  = N'($urandom);
            b  = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 10)) : N'($urandom);
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            operando_A = a; operando_B = b; cod_operacion = op;
            exp_pend = model(a, b, op);
            idle(1);
        end

        i_valid = 1'b0; i_ready = 1'b1;
        idle(6);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d ops still pending want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
